// File: rtl/dyn_branch_predictor.sv
// dyn_branch_predictor
//   Direct-mapped branch target buffer with a saturating taken/not-taken
//   counter per entry. The fetch side gets a combinational prediction for
//   if_pc. The MEM side resolves BEQ/BNE, raises the ID/EX/MEM flushes on a
//   misprediction with no latency, and trains the table on the next rising
//   clock edge. Two saturating statistics counters track resolved branches
//   and mispredictions.
// Ports
//   CLK, nRST                      clock (rising edge), async active-low reset
//   if_pc                          PC being fetched
//   pred_taken, pred_target        prediction and next fetch PC for if_pc
//   res_valid, res_pc, res_instr   MEM-stage instruction (opcode = [31:26])
//   res_zero, res_target           ALU zero flag and computed branch target
//   res_pred_taken/_target         prediction that travelled with the branch
//   flush_ID, flush_EX, flush_MEM  squash on misprediction (all equal)
//   correct_pc                     redirect PC, meaningful while flushing
//   branch_cnt, mispred_cnt        saturating statistics
module dyn_branch_predictor #(
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2,
  parameter int CNT_W    = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [31:0]       if_pc,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  input  logic              res_valid,
  input  logic [31:0]       res_pc,
  input  logic [31:0]       res_instr,
  input  logic              res_zero,
  input  logic [31:0]       res_target,
  input  logic              res_pred_taken,
  input  logic [31:0]       res_pred_target,
  output logic              flush_ID,
  output logic              flush_EX,
  output logic              flush_MEM,
  output logic [31:0]       correct_pc,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  mispred_cnt
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = 32 - IDX - 2;

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_MIN  = {CTR_BITS{1'b0}};
  // Weakly taken: only the MSB set.
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1'b1) << (CTR_BITS - 1);
  localparam logic [CNT_W-1:0]    CNT_MAX  = {CNT_W{1'b1}};

  logic                valid_r  [ENTRIES];
  logic [TAG_W-1:0]    tag_r    [ENTRIES];
  logic [31:0]         target_r [ENTRIES];
  logic [CTR_BITS-1:0] ctr_r    [ENTRIES];

  logic [IDX-1:0] lk_idx_s;
  logic           lk_hit_s;
  logic [IDX-1:0] upd_idx_s;
  logic           upd_hit_s;
  logic [5:0]     opcode_s;
  logic           is_beq_s;
  logic           is_bne_s;
  logic           br_s;
  logic           actual_s;
  logic           mispred_s;
  logic [31:0]    seq_pc_s;
  logic           unused_s;

  // Low PC bits and the non-opcode instruction bits carry no information here.
  assign unused_s = ^{if_pc[1:0], res_pc[1:0], res_instr[25:0]};

  // Fetch-side lookup; reads the pre-update table, so a same-cycle write
  // to the same index shows up one cycle later.
  always_comb begin
    lk_idx_s   = if_pc[IDX+1:2];
    lk_hit_s   = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == if_pc[31:IDX+2]);
    pred_taken = lk_hit_s && ctr_r[lk_idx_s][CTR_BITS-1];
    if (pred_taken) begin
      pred_target = target_r[lk_idx_s];
    end else begin
      pred_target = if_pc + 32'd4;
    end
  end

  // MEM-side resolution: outcome, misprediction and redirect PC.
  always_comb begin
    opcode_s  = res_instr[31:26];
    is_beq_s  = (opcode_s == OP_BEQ);
    is_bne_s  = (opcode_s == OP_BNE);
    br_s      = res_valid && (is_beq_s || is_bne_s);
    actual_s  = (is_beq_s && res_zero) || (is_bne_s && !res_zero);
    seq_pc_s  = res_pc + 32'd4;
    // A taken branch predicted taken but to a stale target still mispredicts.
    mispred_s = br_s && ((actual_s != res_pred_taken) ||
                         (actual_s && (res_pred_target != res_target)));
    if (br_s && actual_s) begin
      correct_pc = res_target;
    end else begin
      correct_pc = seq_pc_s;
    end
    upd_idx_s = res_pc[IDX+1:2];
    upd_hit_s = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == res_pc[31:IDX+2]);
  end

  assign flush_ID  = mispred_s;
  assign flush_EX  = mispred_s;
  assign flush_MEM = mispred_s;

  // Table training on resolved branches; a not-taken miss leaves the table alone.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= {TAG_W{1'b0}};
        target_r[i] <= 32'd0;
        ctr_r[i]    <= CTR_MIN;
      end
    end else if (br_s) begin
      if (upd_hit_s) begin
        if (actual_s) begin
          target_r[upd_idx_s] <= res_target;
          if (ctr_r[upd_idx_s] != CTR_MAX) begin
            ctr_r[upd_idx_s] <= ctr_r[upd_idx_s] + CTR_BITS'(1'b1);
          end
        end else if (ctr_r[upd_idx_s] != CTR_MIN) begin
          ctr_r[upd_idx_s] <= ctr_r[upd_idx_s] - CTR_BITS'(1'b1);
        end
      end else if (actual_s) begin
        valid_r[upd_idx_s]  <= 1'b1;
        tag_r[upd_idx_s]    <= res_pc[31:IDX+2];
        target_r[upd_idx_s] <= res_target;
        ctr_r[upd_idx_s]    <= CTR_WEAK;
      end
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      branch_cnt  <= {CNT_W{1'b0}};
      mispred_cnt <= {CNT_W{1'b0}};
    end else if (br_s) begin
      if (branch_cnt != CNT_MAX) begin
        branch_cnt <= branch_cnt + CNT_W'(1'b1);
      end
      if (mispred_s && (mispred_cnt != CNT_MAX)) begin
        mispred_cnt <= mispred_cnt + CNT_W'(1'b1);
      end
    end
  end

endmodule

// File: tb/tb_dyn_branch_predictor.sv
// Self-checking bench for dyn_branch_predictor: directed scenarios followed
// by randomized traffic, all compared against a behavioural table model.
module tb_dyn_branch_predictor;

  localparam int ENTRIES  = 16;
  localparam int CTR_BITS = 2;
  localparam int CNT_W    = 5;
  localparam int IDXB     = 4;
  localparam int CNT_TOP  = (1 << CNT_W) - 1;
  localparam int CTR_TOP  = (1 << CTR_BITS) - 1;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101;
  localparam logic [5:0] ADD = 6'b000000;
  localparam logic [5:0] LW  = 6'b100011;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic [31:0] if_pc = 32'd0;
  logic pred_taken;
  logic [31:0] pred_target;
  logic res_valid = 1'b0;
  logic [31:0] res_pc = 32'd0;
  logic [31:0] res_instr = 32'd0;
  logic res_zero = 1'b0;
  logic [31:0] res_target = 32'd0;
  logic res_pred_taken = 1'b0;
  logic [31:0] res_pred_target = 32'd0;
  logic flush_ID, flush_EX, flush_MEM;
  logic [31:0] correct_pc;
  logic [CNT_W-1:0] branch_cnt, mispred_cnt;

  int n_total = 0;
  int n_pass  = 0;

  // behavioural model state
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  int          m_br;
  int          m_mp;

  always #5 CLK = ~CLK;

  dyn_branch_predictor #(.ENTRIES(ENTRIES), .CTR_BITS(CTR_BITS), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .res_valid(res_valid), .res_pc(res_pc), .res_instr(res_instr),
    .res_zero(res_zero), .res_target(res_target),
    .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
    .flush_ID(flush_ID), .flush_EX(flush_EX), .flush_MEM(flush_MEM),
    .correct_pc(correct_pc), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic void model_clear();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = 32'd0; m_ctr[i] = 0;
    end
    m_br = 0; m_mp = 0;
  endfunction

  function automatic void model_pred(input logic [31:0] pc, output logic tk, output logic [31:0] tg);
    int i;
    bit hit;
    i   = int'((pc / 4) % ENTRIES);
    hit = m_valid[i] && (m_tag[i] == (pc >> (IDXB + 2)));
    tk  = hit && (m_ctr[i] >= (1 << (CTR_BITS - 1)));
    tg  = tk ? m_tgt[i] : pc + 32'd4;
  endfunction

  // One cycle: drive after negedge, check combinational outputs and the
  // counters, then let the model absorb the resolved branch at posedge.
  task automatic run_cycle(input logic [31:0] ipc, input logic v, input logic [31:0] rpc,
                           input logic [5:0] op, input logic z, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ptg);
    logic e_tk, actual, br, mp;
    logic [31:0] e_tg, e_cpc;
    int i;
    @(negedge CLK);
    if_pc = ipc; res_valid = v; res_pc = rpc; res_zero = z; res_target = tgt;
    res_instr = {op, 26'($urandom)}; res_pred_taken = ptk; res_pred_target = ptg;
    #1;
    model_pred(ipc, e_tk, e_tg);
    br     = v && (op == BEQ || op == BNE);
    actual = (op == BEQ && z) || (op == BNE && !z);
    mp     = br && ((actual != ptk) || (actual && ptg != tgt));
    e_cpc  = (br && actual) ? tgt : rpc + 32'd4;
    check("pred_taken", {31'd0, pred_taken}, {31'd0, e_tk});
    check("pred_target", pred_target, e_tg);
    check("flush_ID", {31'd0, flush_ID}, {31'd0, mp});
    check("flush_EX", {31'd0, flush_EX}, {31'd0, mp});
    check("flush_MEM", {31'd0, flush_MEM}, {31'd0, mp});
    check("correct_pc", correct_pc, e_cpc);
    check("branch_cnt", 32'(branch_cnt), 32'(m_br));
    check("mispred_cnt", 32'(mispred_cnt), 32'(m_mp));
    @(posedge CLK);
    if (br) begin
      i = int'((rpc / 4) % ENTRIES);
      if (m_valid[i] && m_tag[i] == (rpc >> (IDXB + 2))) begin
        if (actual) begin
          m_tgt[i] = tgt;
          if (m_ctr[i] < CTR_TOP) m_ctr[i]++;
        end else if (m_ctr[i] > 0) m_ctr[i]--;
      end else if (actual) begin
        m_valid[i] = 1'b1; m_tag[i] = rpc >> (IDXB + 2);
        m_tgt[i] = tgt; m_ctr[i] = 1 << (CTR_BITS - 1);
      end
      if (m_br < CNT_TOP) m_br++;
      if (mp && m_mp < CNT_TOP) m_mp++;
    end
  endtask

  // Resolve a branch whose carried prediction is what the model predicts now.
  task automatic resolve(input logic [31:0] rpc, input logic [5:0] op, input logic z,
                         input logic [31:0] tgt);
    logic tk;
    logic [31:0] tg;
    model_pred(rpc, tk, tg);
    run_cycle(rpc, 1'b1, rpc, op, z, tgt, tk, tg);
  endtask

  // Lookup only, compared against constants.
  task automatic peek(input string tag, input logic [31:0] ipc, input logic e_tk,
                      input logic [31:0] e_tg);
    @(negedge CLK);
    if_pc = ipc; res_valid = 1'b0; #1;
    check({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, e_tk});
    check({tag, "_target"}, pred_target, e_tg);
  endtask

  // Mid-stream reset: everything cleared immediately; flush still follows res_*.
  task automatic do_reset(input logic [31:0] ipc);
    @(negedge CLK);
    if_pc = ipc; res_valid = 1'b1; res_pc = 32'h300; res_instr = {BEQ, 26'd0};
    res_zero = 1'b1; res_target = 32'h500; res_pred_taken = 1'b0;
    nRST = 1'b0; #1;
    check("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    check("rst_pred_target", pred_target, ipc + 32'd4);
    check("rst_branch_cnt", 32'(branch_cnt), 32'd0);
    check("rst_mispred_cnt", 32'(mispred_cnt), 32'd0);
    check("rst_flush", {31'd0, flush_MEM}, 32'd1);
    check("rst_correct_pc", correct_pc, 32'h500);
    model_clear();
    @(negedge CLK);
    res_valid = 1'b0; nRST = 1'b1;
  endtask

  initial begin
    logic tk;
    logic [31:0] tg, rpc, tgt;
    logic [5:0] op;
    int r;
    model_clear();
    repeat (2) @(negedge CLK);
    nRST = 1'b1;

    // 1: first BEQ allocates, next lookup predicts taken
    peek("t1_cold", 32'h100, 1'b0, 32'h104);
    run_cycle(32'h100, 1'b1, 32'h100, BEQ, 1'b1, 32'h200, 1'b0, 32'h104);
    peek("t1_trained", 32'h100, 1'b1, 32'h200);
    // 2: saturate then decay to not-taken
    repeat (3) resolve(32'h100, BEQ, 1'b1, 32'h200);
    repeat (2) resolve(32'h100, BEQ, 1'b0, 32'h200);
    peek("t2_decayed", 32'h100, 1'b0, 32'h104);
    // 3: BNE with stale target
    run_cycle(32'h0, 1'b1, 32'h40, BNE, 1'b0, 32'h90, 1'b1, 32'h80);
    peek("t3_retarget", 32'h40, 1'b1, 32'h90);
    // 4: aliasing eviction
    resolve(32'h100, BEQ, 1'b1, 32'h200);
    resolve(32'h100 + 4 * ENTRIES, BEQ, 1'b1, 32'h600);
    peek("t4_evicted", 32'h100, 1'b0, 32'h104);
    peek("t4_alias", 32'h100 + 4 * ENTRIES, 1'b1, 32'h600);
    // 5: non-branches leave everything alone; then reset mid-stream
    run_cycle(32'h40, 1'b1, 32'h40, ADD, 1'b1, 32'h900, 1'b0, 32'h44);
    run_cycle(32'h40, 1'b0, 32'h40, BEQ, 1'b1, 32'h900, 1'b0, 32'h44);
    run_cycle(32'h40, 1'b0, 32'h40, BEQ, 1'b0, 32'h900, 1'b0, 32'h44);
    do_reset(32'h40);
    peek("t5_after_rst", 32'h40, 1'b0, 32'h44);
    // 6: mispredict counter saturation
    for (int k = 0; k < CNT_TOP + 3; k++)
      run_cycle(32'h0, 1'b1, 32'h10, BEQ, 1'b1, 32'h20, 1'b0, 32'h14);
    run_cycle(32'h0, 1'b0, 32'h0, ADD, 1'b0, 32'h0, 1'b0, 32'h4);
    check("t6_mispred_sat", 32'(mispred_cnt), 32'(CNT_TOP));
    do_reset(32'h10);

    // randomized traffic over a small PC set so hits and aliases are frequent
    for (int n = 0; n < 400; n++) begin
      if (n == 200) do_reset(32'($urandom_range(0, 47)) << 2);
      rpc = 32'($urandom_range(0, 47)) << 2;
      tgt = 32'($urandom_range(0, 7)) << 4;
      r   = $urandom_range(0, 9);
      op  = (r < 4) ? BEQ : (r < 8) ? BNE : (r == 8) ? ADD : LW;
      model_pred(rpc, tk, tg);
      if ($urandom_range(0, 9) < 3) begin
        tk = 1'($urandom);
        tg = 32'($urandom_range(0, 7)) << 4;
      end
      run_cycle(32'($urandom_range(0, 47)) << 2, ($urandom_range(0, 9) != 0), rpc, op,
                1'($urandom), tgt, tk, tg);
    end
    run_cycle(32'h0, 1'b0, 32'h0, ADD, 1'b0, 32'h0, 1'b0, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
